// File: rtl/replay_pkg.sv
// replay_pkg: shared state type and sequence helpers for the
// data-link replay buffer.
package replay_pkg;

  localparam int SEQ_W_DEF = 12;

  typedef enum logic {
    SEND,
    REPLAY
  } state_e;

  function automatic logic [SEQ_W_DEF-1:0] seq_diff(
    input logic [SEQ_W_DEF-1:0] a,
    input logic [SEQ_W_DEF-1:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/replay_ram.sv
// replay_ram: DEPTH x W storage, one write port and one
// registered read port that doubles as the output data register.
module replay_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 140
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-1:0]             o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/replay_buffer.sv
// replay_buffer: sequences, holds and retransmits framed TLPs.
// Define REPLAY_TIMER_EN for the ACK/NAK timeout replay.
module replay_buffer
  import replay_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = SEQ_W_DEF
`ifdef REPLAY_TIMER_EN
  ,
  parameter int REPLAY_TIMEOUT = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   ack_valid,
  input  logic                   ack_nak,
  input  logic [SEQ_W-1:0]       ack_seq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEQ_W-1:0]       out_seq,
  output logic                   out_replay,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   retrain
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = SEQ_W + DATA_W;

  state_e r_state, w_state_nx;

  logic [PW-1:0]    r_wr, r_rd, r_tx, r_end;
  logic [PW-1:0]    w_rd_nx, w_tx_nx;
  logic [PW-1:0]    w_tx_adv, w_end_nx, w_sent;
  logic [SEQ_W-1:0] r_seq, w_rd_seq, w_d;
  logic [1:0]       r_rnum;
  logic             r_retrain, r_ovalid, r_oreplay;
  logic             w_wr, w_xfer, w_hit, w_nak;
  logic             w_tfire, w_load, w_ovalid_nx;
  logic [EW-1:0]    w_rdata;

  assign count    = r_wr - r_rd;
  assign full     = (count == PW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

  assign w_wr   = in_valid && !full;
  assign w_xfer = r_ovalid && out_ready;
  assign w_sent = r_tx - r_rd;

  // Entries are contiguous, so the oldest seq is derived.
  assign w_rd_seq = seq_diff(r_seq, SEQ_W'(count));
  assign w_d      = seq_diff(ack_seq, w_rd_seq);
  assign w_hit    = ack_valid
                 && (w_d < SEQ_W'(w_sent));
  assign w_rd_nx  = w_hit
                  ? r_rd + PW'(w_d) + PW'(1)
                  : r_rd;

  assign w_nak    = (ack_valid && ack_nak) || w_tfire;
  assign w_tx_adv = r_tx + PW'(w_xfer);
  assign w_end_nx = (w_nak && r_state == SEND)
                  ? w_tx_adv
                  : r_end;

  always_comb begin
    w_state_nx = r_state;
    w_tx_nx    = w_tx_adv;
    if (w_nak) begin
      w_tx_nx    = w_rd_nx;
      w_state_nx = (w_rd_nx != w_end_nx)
                 ? REPLAY : SEND;
    end else if (r_state == REPLAY
              && w_tx_adv == r_end) begin
      w_state_nx = SEND;
    end
  end

  // Prefetch the word after tx so transfers run back to back.
  assign w_load = !w_nak
               && (!r_ovalid || out_ready)
               && (w_tx_adv != r_wr);
  assign w_ovalid_nx = w_load
                    || (r_ovalid && !out_ready && !w_nak);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= SEND;
    else      r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_tx      <= '0;
      r_end     <= '0;
      r_seq     <= '0;
      r_rnum    <= '0;
      r_retrain <= 1'b0;
      r_ovalid  <= 1'b0;
      r_oreplay <= 1'b0;
    end else begin
      r_wr      <= r_wr + PW'(w_wr);
      r_rd      <= w_rd_nx;
      r_tx      <= w_tx_nx;
      r_end     <= w_end_nx;
      r_seq     <= r_seq + SEQ_W'(w_wr);
      r_retrain <= w_nak && (r_rnum == 2'd3);
      r_ovalid  <= w_ovalid_nx;
      if (w_nak)      r_rnum <= r_rnum + 2'd1;
      else if (w_hit) r_rnum <= '0;
      if (w_load)
        r_oreplay <= (r_state == REPLAY)
                  && (w_tx_adv != r_end);
    end
  end

`ifdef REPLAY_TIMER_EN
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  logic [TW-1:0] r_tmr;

  assign w_tfire = (w_sent != '0)
                && (r_tmr == TW'(REPLAY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || w_sent == '0 || w_hit || w_nak)
      r_tmr <= '0;
    else
      r_tmr <= r_tmr + TW'(1);
  end
`else
  assign w_tfire = 1'b0;
`endif

  replay_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr[AW-1:0]),
    .i_wr_data ({r_seq, in_data}),
    .i_rd_en   (w_load),
    .i_rd_addr (w_tx_adv[AW-1:0]),
    .o_rd_data (w_rdata)
  );

  assign out_valid  = r_ovalid;
  assign out_replay = r_oreplay;
  assign out_seq    = w_rdata[EW-1:DATA_W];
  assign out_data   = w_rdata[DATA_W-1:0];
  assign retrain    = r_retrain;

endmodule
